// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request, ALU and response signals of the shared-ALU arbiter
interface alu_arbiter_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  r0_valid;
  logic                  r0_ready;
  logic [WORD_WIDTH-1:0] r0_a;
  logic [WORD_WIDTH-1:0] r0_b;
  logic [4:0]            r0_sa;
  logic [4:0]            r0_opcode;

  logic                  r1_valid;
  logic                  r1_ready;
  logic [WORD_WIDTH-1:0] r1_a;
  logic [WORD_WIDTH-1:0] r1_b;
  logic [4:0]            r1_sa;
  logic [4:0]            r1_opcode;

  logic [WORD_WIDTH-1:0] alu_a;
  logic [WORD_WIDTH-1:0] alu_b;
  logic [4:0]            alu_sa;
  logic [4:0]            alu_opcode;
  logic [WORD_WIDTH-1:0] alu_resultado;
  logic                  alu_zero;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [WORD_WIDTH-1:0] rsp_resultado;
  logic                  rsp_zero;

  modport slave (
    input  r0_valid, r0_a, r0_b, r0_sa, r0_opcode,
    input  r1_valid, r1_a, r1_b, r1_sa, r1_opcode,
    input  alu_resultado, alu_zero, rsp_ready,
    output r0_ready, r1_ready,
    output alu_a, alu_b, alu_sa, alu_opcode,
    output rsp_valid, rsp_id, rsp_resultado, rsp_zero
  );

  modport master (
    output r0_valid, r0_a, r0_b, r0_sa, r0_opcode,
    output r1_valid, r1_a, r1_b, r1_sa, r1_opcode,
    output alu_resultado, alu_zero, rsp_ready,
    input  r0_ready, r1_ready,
    input  alu_a, alu_b, alu_sa, alu_opcode,
    input  rsp_valid, rsp_id, rsp_resultado, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port arbiter sharing one combinational ALU with tagged responses
module alu_arbiter #(
  parameter int WORD_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  state_t                r_state;
  state_t                w_next_state;
  logic [3:0]            r_starve_cnt;
  logic                  r_pend_id;
  logic [WORD_WIDTH-1:0] r_alu_a;
  logic [WORD_WIDTH-1:0] r_alu_b;
  logic [4:0]            r_alu_sa;
  logic [4:0]            r_alu_opcode;
  logic                  r_rsp_valid;
  logic                  r_rsp_id;
  logic [WORD_WIDTH-1:0] r_rsp_resultado;
  logic                  r_rsp_zero;
  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_starved;

  assign w_starved = (r_starve_cnt == LP_LIMIT);

  // Grant selection (IDLE only, suppressed while reset is low) and next-state logic
  always_comb begin
    w_next_state = r_state;
    w_grant0     = 1'b0;
    w_grant1     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (reset) begin
          if (bus.r1_valid && (!bus.r0_valid || w_starved)) begin
            w_grant1 = 1'b1;
          end else if (bus.r0_valid) begin
            w_grant0 = 1'b1;
          end
        end
        if (w_grant0 || w_grant1) begin
          w_next_state = EXEC;
        end
      end
      EXEC: w_next_state = RESP;
      RESP: begin
        if (r_rsp_valid && bus.rsp_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Starvation counter: port-0 wins while port 1 waits, saturating; port-1 win clears it
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_starve_cnt <= 4'd0;
    end else if (w_grant1) begin
      r_starve_cnt <= 4'd0;
    end else if (w_grant0 && bus.r1_valid && (r_starve_cnt < LP_LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Operand load on grant, result capture after the EXEC cycle, response handshake
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_alu_a         <= '0;
      r_alu_b         <= '0;
      r_alu_sa        <= '0;
      r_alu_opcode    <= '0;
      r_pend_id       <= 1'b0;
      r_rsp_valid     <= 1'b0;
      r_rsp_id        <= 1'b0;
      r_rsp_resultado <= '0;
      r_rsp_zero      <= 1'b0;
    end else begin
      if (w_grant0) begin
        r_alu_a      <= bus.r0_a;
        r_alu_b      <= bus.r0_b;
        r_alu_sa     <= bus.r0_sa;
        r_alu_opcode <= bus.r0_opcode;
        r_pend_id    <= 1'b0;
      end else if (w_grant1) begin
        r_alu_a      <= bus.r1_a;
        r_alu_b      <= bus.r1_b;
        r_alu_sa     <= bus.r1_sa;
        r_alu_opcode <= bus.r1_opcode;
        r_pend_id    <= 1'b1;
      end
      if (r_state == EXEC) begin
        r_rsp_resultado <= bus.alu_resultado;
        r_rsp_zero      <= bus.alu_zero;
        r_rsp_id        <= r_pend_id;
        r_rsp_valid     <= 1'b1;
      end else if ((r_state == RESP) && bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.r0_ready      = w_grant0;
  assign bus.r1_ready      = w_grant1;
  assign bus.alu_a         = r_alu_a;
  assign bus.alu_b         = r_alu_b;
  assign bus.alu_sa        = r_alu_sa;
  assign bus.alu_opcode    = r_alu_opcode;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_id        = r_rsp_id;
  assign bus.rsp_resultado = r_rsp_resultado;
  assign bus.rsp_zero      = r_rsp_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a reference ALU and arbiter model
module tb_alu_arbiter;
  localparam int W   = 32;
  localparam int LIM = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WORD_WIDTH(W)) bus ();

  alu_arbiter #(.WORD_WIDTH(W), .STARVE_LIMIT(LIM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [4:0] sa, input logic [4:0] op);
    case (op)
      5'b00010: return a + b;
      5'b00110: return a - b;
      5'b00100: return b << sa;
      5'b00000: return a & b;
      5'b00001: return a | b;
      default:  return a ^ b;
    endcase
  endfunction

  assign bus.alu_resultado = alu_f(bus.alu_a, bus.alu_b, bus.alu_sa, bus.alu_opcode);
  assign bus.alu_zero      = (bus.alu_resultado == '0);

  typedef struct {
    logic         id;
    logic [W-1:0] res;
    logic         zero;
    int           acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic         p_v[2];
  logic         p_done[2];
  logic [W-1:0] p_a[2];
  logic [W-1:0] p_b[2];
  logic [4:0]   p_sa[2];
  logic [4:0]   p_op[2];

  int m_starve     = 0;
  bit m_busy       = 0;
  bit m_release    = 0;
  bit prev_rst_low = 0;
  int req_mode     = 2;
  int rsp_mode     = 0;

  logic         last_id;
  logic [W-1:0] last_res;
  logic         last_zero;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic set_req(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] sa, input logic [4:0] op);
    p_v[p]  = 1'b1;
    p_a[p]  = a;
    p_b[p]  = b;
    p_sa[p] = sa;
    p_op[p] = op;
  endtask

  task automatic new_req(input int p);
    logic [4:0] ops[6];
    logic [W-1:0] a;
    ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b00110, 5'b00111};
    a = $urandom;
    set_req(p, a, ($urandom_range(0, 3) == 0) ? a : W'($urandom),
            5'($urandom_range(0, 31)), ops[$urandom_range(0, 5)]);
  endtask

  task automatic drive();
    bus.r0_valid  = p_v[0];
    bus.r0_a      = p_a[0];
    bus.r0_b      = p_b[0];
    bus.r0_sa     = p_sa[0];
    bus.r0_opcode = p_op[0];
    bus.r1_valid  = p_v[1];
    bus.r1_a      = p_a[1];
    bus.r1_b      = p_b[1];
    bus.r1_sa     = p_sa[1];
    bus.r1_opcode = p_op[1];
    case (rsp_mode)
      0:       bus.rsp_ready = 1'b1;
      1:       bus.rsp_ready = ($urandom_range(0, 2) != 0);
      default: bus.rsp_ready = 1'b0;
    endcase
  endtask

  // Reference arbiter: one operation outstanding, fixed priority with starvation escape
  task automatic sample();
    logic e0, e1;
    int   w;
    if (!reset) begin
      check("ready0_in_reset", bus.r0_ready, 0);
      check("ready1_in_reset", bus.r1_ready, 0);
      if (m_busy) void'(exp_q.pop_back());
      m_busy       = 0;
      m_release    = 0;
      m_starve     = 0;
      prev_rst_low = 1;
      return;
    end
    if (prev_rst_low) begin
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_id", bus.rsp_id, 0);
      check("rst_rsp_res", bus.rsp_resultado, 0);
      check("rst_rsp_zero", bus.rsp_zero, 0);
      check("rst_alu_a", bus.alu_a, 0);
      check("rst_alu_b", bus.alu_b, 0);
      check("rst_alu_sa", bus.alu_sa, 0);
      check("rst_alu_op", bus.alu_opcode, 0);
      prev_rst_low = 0;
    end
    if (m_release) begin
      m_busy    = 0;
      m_release = 0;
    end
    e0 = 0;
    e1 = 0;
    if (!m_busy) begin
      if (p_v[1] && (!p_v[0] || m_starve == LIM)) e1 = 1;
      else if (p_v[0]) e0 = 1;
    end
    check("r0_ready", bus.r0_ready, e0);
    check("r1_ready", bus.r1_ready, e1);
    if (e0 || e1) begin
      w = e1 ? 1 : 0;
      exp_q.push_back('{id: e1, res: alu_f(p_a[w], p_b[w], p_sa[w], p_op[w]),
                        zero: (alu_f(p_a[w], p_b[w], p_sa[w], p_op[w]) == '0), acc_cyc: cyc});
      grant_log.push_back(w);
      if (e1) m_starve = 0;
      else if (p_v[1] && m_starve < LIM) m_starve++;
      m_busy    = 1;
      p_done[w] = 1;
    end
    if (m_busy && bus.rsp_valid && bus.rsp_ready) m_release = 1;
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (p_done[p]) begin
        p_v[p]    = 1'b0;
        p_done[p] = 1'b0;
      end
      if (req_mode == 1 && !p_v[p]) new_req(p);
      else if (req_mode == 3 && !p_v[p] && $urandom_range(0, 4) < 2) new_req(p);
      else if (req_mode == 3 && p_v[p] && $urandom_range(0, 7) == 0) p_v[p] = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((p_v[0] || p_v[1] || m_busy || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (p_v[0] || p_v[1] || m_busy || exp_q.size() != 0) fail_now("drain_timeout");
  endtask

  // Response monitor: latency, stability under backpressure, and payload against the scoreboard
  logic         mon_prev_v = 0;
  logic         mon_prev_r = 0;
  logic         mon_id;
  logic [W-1:0] mon_res;
  logic         mon_zero;

  always @(negedge clk) begin
    if (!reset) begin
      mon_prev_v = 0;
      mon_prev_r = 0;
    end else begin
      if (bus.rsp_valid && !mon_prev_v) begin
        if (exp_q.size() == 0) fail_now("unexpected_rsp");
        else check("rsp_latency", 64'(cyc - exp_q[0].acc_cyc), 2);
      end
      if (bus.rsp_valid && mon_prev_v && !mon_prev_r) begin
        check("hold_id", bus.rsp_id, mon_id);
        check("hold_res", bus.rsp_resultado, mon_res);
        check("hold_zero", bus.rsp_zero, mon_zero);
      end
      if (bus.rsp_valid && bus.rsp_ready && exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_id", bus.rsp_id, e.id);
        check("rsp_res", bus.rsp_resultado, e.res);
        check("rsp_zero", bus.rsp_zero, e.zero);
        last_id   = bus.rsp_id;
        last_res  = bus.rsp_resultado;
        last_zero = bus.rsp_zero;
      end
      mon_prev_v = bus.rsp_valid;
      mon_prev_r = bus.rsp_ready;
      mon_id     = bus.rsp_id;
      mon_res    = bus.rsp_resultado;
      mon_zero   = bus.rsp_zero;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[10];
    int n;
    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int p = 0; p < 2; p++) begin
      p_done[p] = 0;
      new_req(p);
    end
    reset = 1'b0;
    repeat (3) step();
    p_v[0] = 0;
    p_v[1] = 0;
    reset  = 1'b1;
    step();

    set_req(0, 32'd5, 32'd7, 5'd0, 5'b00010);
    drain(20);
    check("add_res", last_res, 12);
    check("add_zero", last_zero, 0);
    check("add_id", last_id, 0);

    set_req(1, 32'd9, 32'd9, 5'd0, 5'b00110);
    drain(20);
    check("sub_res", last_res, 0);
    check("sub_zero", last_zero, 1);
    check("sub_id", last_id, 1);

    rsp_mode = 2;
    set_req(0, 32'd0, 32'd1, 5'd4, 5'b00100);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      step();
      n++;
    end
    if (!bus.rsp_valid) fail_now("sll_rsp_timeout");
    repeat (3) step();
    rsp_mode = 0;
    drain(20);
    check("sll_res", last_res, 16);

    set_req(0, W'($urandom), W'($urandom), 5'd3, 5'b00010);
    n = 0;
    while (p_v[0] && n < 20) begin
      step();
      n++;
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    repeat (4) step();
    set_req(1, 32'd100, 32'd1, 5'd0, 5'b00110);
    drain(20);
    check("post_rst_id", last_id, 1);
    check("post_rst_res", last_res, 99);

    grant_log.delete();
    set_req(0, 32'd1, 32'd2, 5'd0, 5'b00010);
    set_req(1, 32'd3, 32'd4, 5'd0, 5'b00010);
    drain(30);
    check("both_cnt", 64'(grant_log.size()), 2);
    if (grant_log.size() >= 2) begin
      check("both_first", 64'(grant_log[0]), 0);
      check("both_second", 64'(grant_log[1]), 1);
    end

    grant_log.delete();
    req_mode = 1;
    n = 0;
    while (grant_log.size() < 10 && n < 200) begin
      step();
      n++;
    end
    req_mode = 2;
    drain(100);
    if (grant_log.size() < 10) fail_now("order_timeout");
    else for (int i = 0; i < 10; i++) check($sformatf("order_%0d", i), 64'(grant_log[i]), 64'(exp_order[i]));

    req_mode = 3;
    rsp_mode = 1;
    repeat (600) step();
    req_mode = 2;
    rsp_mode = 0;
    p_v[0] = p_done[0] ? p_v[0] : 1'b0;
    p_v[1] = p_done[1] ? p_v[1] : 1'b0;
    drain(100);
    check("queue_empty", 64'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
